// File: rtl/uart_rx_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_ctrl_pkg                                             |
// | Description : Shared types and constants for the UART receive sequencer.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package uart_rx_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_LOAD = 2'd1,
        CNT_INC  = 2'd2
    } cnt_mode_e;

    // Oversampling tick counts: mid start bit, last tick of a full bit period.
    localparam int START_MID = 7;
    localparam int BIT_LAST  = 15;

    // Maps a counter mode onto the {en, en_count} pair of the counter register.
    function automatic logic [1:0] cnt_drive(input cnt_mode_e mode);
        logic [1:0] drv;
        drv = 2'b00;
        case (mode)
            CNT_LOAD: drv = 2'b10;
            CNT_INC:  drv = 2'b11;
            default:  drv = 2'b00;
        endcase
        return drv;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_ctrl_if                                              |
// | Description : Counter-register handshake and received-word outputs.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface uart_rx_ctrl_if #(
    parameter int CNT_W = 8,
    parameter int DBIT  = 8
);
    logic             cnt_en;
    logic             cnt_en_count;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;
    logic [DBIT-1:0]  dout;
    logic             rx_done_tick;
    logic             frame_err;
    logic             parity_err;

    modport master (
        input  cnt_q,
        output cnt_en, cnt_en_count, cnt_d,
        output dout, rx_done_tick, frame_err, parity_err
    );

    modport slave (
        output cnt_q,
        input  cnt_en, cnt_en_count, cnt_d,
        input  dout, rx_done_tick, frame_err, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl_rx_sync.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rx_sync                                                      |
// | Description : Two-flop synchronizer for the serial line, resets to idle.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rx_sync (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic d,
    output logic      q
);
    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[1];
endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : uart_rx_ctrl                                                 |
// | Description : 16x oversampled UART receive sequencer driving an external  |
// |               loadable counter. Optional parity: UART_PARITY_EN.           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int CNT_W   = 8,
    parameter int PAR_ODD = 0
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      rx,
    input  wire logic      s_tick,
    uart_rx_ctrl_if.master bus
);
    localparam int               N_W      = $clog2(DBIT);
    localparam logic [N_W-1:0]   N_LAST   = N_W'(DBIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(START_MID);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_LAST);
    localparam logic [CNT_W-1:0] CNT_STOP = CNT_W'(SB_TICK - 1);

    logic            rx_s;
    rx_state_e       state_q, state_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] shift_q, shift_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            ferr_q, ferr_d;
    cnt_mode_e       mode;

`ifdef UART_PARITY_EN
    localparam logic PAR_SENSE = (PAR_ODD != 0);
    logic par_q, par_d;
    logic perr_q, perr_d;
`endif

    rx_sync u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        shift_d = shift_q;
        dout_d  = dout_q;
        ferr_d  = ferr_q;
        done_d  = 1'b0;
        mode    = CNT_HOLD;
`ifdef UART_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    mode    = CNT_LOAD;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (bus.cnt_q == CNT_MID) begin
                        if (!rx_s) begin
                            mode    = CNT_LOAD;
                            n_d     = '0;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        mode = CNT_INC;
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (bus.cnt_q == CNT_LAST) begin
                        mode    = CNT_LOAD;
                        shift_d = {rx_s, shift_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            n_d = n_q + N_W'(1);
                        end
                    end else begin
                        mode = CNT_INC;
                    end
                end
            end
`ifdef UART_PARITY_EN
            ST_PARITY: begin
                if (s_tick) begin
                    if (bus.cnt_q == CNT_LAST) begin
                        mode    = CNT_LOAD;
                        par_d   = rx_s;
                        state_d = ST_STOP;
                    end else begin
                        mode = CNT_INC;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (s_tick) begin
                    if (bus.cnt_q == CNT_STOP) begin
                        dout_d  = shift_q;
                        ferr_d  = ~rx_s;
                        done_d  = 1'b1;
`ifdef UART_PARITY_EN
                        perr_d  = (^shift_q) ^ par_q ^ PAR_SENSE;
`endif
                        state_d = ST_IDLE;
                    end else begin
                        mode = CNT_INC;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            n_q     <= '0;
            shift_q <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            ferr_q  <= ferr_d;
`ifdef UART_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign {bus.cnt_en, bus.cnt_en_count} = cnt_drive(mode);
    assign bus.cnt_d        = '0;
    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = ferr_q;
`ifdef UART_PARITY_EN
    assign bus.parity_err   = perr_q;
`else
    assign bus.parity_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_uart_rx_ctrl                                              |
// | Description : Self-checking bench for uart_rx_ctrl with a counter model.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_uart_rx_ctrl;
    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
    localparam int CNT_W   = 8;
    localparam int PAR_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int PAR_TICKS = 16;
`else
    localparam int PAR_TICKS = 0;
`endif
    // Start-edge to done-tick distance in oversampling ticks.
    localparam int EXP_LAT = 8 + 16 * DBIT + PAR_TICKS + SB_TICK;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx  = 1'b1;
    logic s_tick = 1'b0;
    logic [1:0] div = 2'd0;
    int tick_cnt = 0;
    logic [CNT_W-1:0] cnt_model = '0;

    int total = 0;
    int bad   = 0;

    int done_cnt = 0;
    int done_at  = 0;
    int double_pulse = 0;
    logic prev_done = 1'b0;
    logic [DBIT-1:0] cap_dout = '0;
    logic cap_ferr = 1'b0;
    logic cap_perr = 1'b0;

    logic [DBIT-1:0] model_dout = '0;
    logic model_ferr = 1'b0;
    logic model_perr = 1'b0;

    uart_rx_ctrl_if #(.CNT_W(CNT_W), .DBIT(DBIT)) bus ();

    uart_rx_ctrl #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK),
        .CNT_W   (CNT_W),
        .PAR_ODD (PAR_ODD)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rx     (rx),
        .s_tick (s_tick),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Baud generator: one tick every 4 clocks.
    always @(posedge clk) begin
        div    <= div + 2'd1;
        s_tick <= (div == 2'd3);
        if (s_tick) tick_cnt <= tick_cnt + 1;
    end

    // External counter register; unaffected by the sequencer's reset.
    always @(posedge clk) begin
        if (bus.cnt_en) cnt_model <= bus.cnt_en_count ? cnt_model + 1'b1 : bus.cnt_d;
    end
    assign bus.cnt_q = cnt_model;

    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_at  = tick_cnt;
            cap_dout = bus.dout;
            cap_ferr = bus.frame_err;
            cap_perr = bus.parity_err;
            if (prev_done) double_pulse = double_pulse + 1;
        end
        prev_done = bus.rx_done_tick;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Returns 1 time unit after the n-th following s_tick edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(posedge clk); while (s_tick !== 1'b1);
            #1;
        end
    endtask

    function automatic logic good_par(input logic [DBIT-1:0] data);
        return (^data) ^ PAR_ODD[0];
    endfunction

    task automatic send_frame(input string tag, input logic [DBIT-1:0] data,
                              input logic stop_ok, input logic par_bit, input int gap);
        int d0;
        int t0;
        logic exp_perr;
        d0 = done_cnt;
        wait_ticks(1);
        rx = 1'b0;
        t0 = tick_cnt;
        wait_ticks(16);
        for (int i = 0; i < DBIT; i++) begin
            rx = data[i];
            wait_ticks(16);
        end
`ifdef UART_PARITY_EN
        rx = par_bit;
        wait_ticks(16);
        exp_perr = (^data) ^ par_bit ^ PAR_ODD[0];
`else
        exp_perr = 1'b0 & par_bit;
`endif
        if (stop_ok) begin
            rx = 1'b1;
            wait_ticks(SB_TICK);
        end else begin
            // Low just past the sample point so the re-entered START is a false start.
            rx = 1'b0;
            wait_ticks(SB_TICK / 2 + 2);
            rx = 1'b1;
            wait_ticks(SB_TICK / 2 - 2);
        end
        wait_ticks(gap);
        model_dout = data;
        model_ferr = ~stop_ok;
        model_perr = exp_perr;
        check({tag, ".done"}, done_cnt - d0, 1);
        check({tag, ".dout"}, cap_dout, model_dout);
        check({tag, ".ferr"}, cap_ferr, model_ferr);
        check({tag, ".perr"}, cap_perr, model_perr);
        check({tag, ".lat"}, ((done_at - t0 >= EXP_LAT - 1) && (done_at - t0 <= EXP_LAT + 1)) ? 1 : 0, 1);
    endtask

    initial begin
        logic [DBIT-1:0] data;
        logic stop_ok;
        int d0;

        repeat (3) @(negedge clk);
        check("rst.dout", bus.dout, 0);
        check("rst.done", bus.rx_done_tick, 0);
        check("rst.ferr", bus.frame_err, 0);
        check("rst.perr", bus.parity_err, 0);
        check("rst.cnt_en", {bus.cnt_en, bus.cnt_en_count}, 0);
        check("rst.cnt_d", bus.cnt_d, 0);
        rst = 1'b1;
        wait_ticks(4);

        send_frame("f55", 8'h55, 1'b1, good_par(8'h55), 2);
        send_frame("fA3", 8'hA3, 1'b1, good_par(8'hA3), 0);
        send_frame("f0F", 8'h0F, 1'b1, good_par(8'h0F), 2);

        d0 = done_cnt;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        wait_ticks(30);
        check("glitch.done", done_cnt - d0, 0);
        check("glitch.dout", bus.dout, model_dout);

        send_frame("fFF_bad", 8'hFF, 1'b0, good_par(8'hFF), 2);
        send_frame("f12", 8'h12, 1'b1, good_par(8'h12), 2);

        // Abort a frame of 0x3C halfway through data bit 4.
        d0 = done_cnt;
        data = 8'h3C;
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx = data[i];
            wait_ticks(16);
        end
        rx = data[4];
        wait_ticks(8);
        rst = 1'b0;
        #1;
        check("abort.dout", bus.dout, 0);
        check("abort.done", bus.rx_done_tick, 0);
        check("abort.ferr", bus.frame_err, 0);
        check("abort.cnt_en", {bus.cnt_en, bus.cnt_en_count}, 0);
        model_dout = '0;
        model_ferr = 1'b0;
        model_perr = 1'b0;
        wait_ticks(2);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wait_ticks(30);
        check("abort.nodone", done_cnt - d0, 0);
        check("abort.hold", bus.dout, 0);
        send_frame("f81", 8'h81, 1'b1, good_par(8'h81), 2);

`ifdef UART_PARITY_EN
        send_frame("f07_p1", 8'h07, 1'b1, 1'b1, 2);
        send_frame("f07_p0", 8'h07, 1'b1, 1'b0, 2);
`endif

        for (int k = 0; k < 8; k++) begin
            data    = DBIT'($urandom);
            stop_ok = ($urandom_range(0, 3) != 0);
            send_frame($sformatf("rnd%0d", k), data, stop_ok, 1'($urandom), $urandom_range(0, 3));
        end

        check("single_pulse", double_pulse, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Receive-side sequencer for the UART. Drives the shared loadable counter register (cnt_reg: en=1,en_count=0 loads d; en=1,en_count=1 increments; en=0 holds; q valid the cycle after the load or increment edge).
- Uses that counter to time 16x-oversampled bit periods. Tracks bit index and shift data internally. Emits one received word per frame with a done tick and error flags.

Parameters:
- DBIT, 8, data bits per frame (5..9).
- SB_TICK, 16, oversampling ticks in stop bit (16/24/32 for 1/1.5/2 stop bits).
- CNT_W, 8, width of the external counter register (>= 5).
- PAR_ODD, 0, parity sense when UART_PARITY_EN is defined. 0 = even, 1 = odd.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rx  in  1  serial line, asynchronous, idle high.
- s_tick  in  1  one-cycle pulse at 16x baud from the baud generator.
- cnt_q  in  CNT_W  counter register output.
- cnt_en  out  1  counter register enable.
- cnt_en_count  out  1  counter register count select.
- cnt_d  out  CNT_W  counter register load value (always 0).
- dout  out  DBIT  last received word.
- rx_done_tick  out  1  one-cycle pulse, frame complete.
- frame_err  out  1  stop bit sampled low on last frame.
- parity_err  out  1  parity mismatch on last frame (0 without macro).

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, synced rx=1, bit index n=0, shift reg=0.
  - dout=0, rx_done_tick=0, frame_err=0, parity_err=0.
  - cnt_en=0, cnt_en_count=0, cnt_d=0.
- Input sync: rx passes through a 2-FF synchronizer (reset value 1). rx_s is the synced value; all decisions use rx_s.
- Counter drive (combinational from state, s_tick, cnt_q):
  - LOAD: cnt_en=1, cnt_en_count=0.
  - INC: cnt_en=1, cnt_en_count=1.
  - otherwise both 0.
  - cnt_d is constant 0.
- IDLE: if rx_s=0 -> LOAD, go START. Otherwise no counter activity.
- START, on s_tick:
  - if cnt_q==7 and rx_s=0 -> LOAD, n=0, go DATA.
  - if cnt_q==7 and rx_s=1 -> false start: go IDLE, no done tick.
  - otherwise INC.
- DATA, on s_tick:
  - if cnt_q==15 -> LOAD, shift = {rx_s, shift[DBIT-1:1]} (LSB first).
  - Then if n==DBIT-1 go STOP (or PARITY with macro), else n=n+1.
  - otherwise INC.
- STOP, on s_tick:
  - if cnt_q==SB_TICK-1 -> dout=shift, frame_err=~rx_s, rx_done_tick=1 for exactly one cycle, go IDLE.
  - otherwise INC.
- Cycles without s_tick: counter held (en=0), state unchanged.
- Latency: rx_done_tick asserts the cycle after the STOP s_tick where cnt_q==SB_TICK-1.
- dout, frame_err and parity_err hold until the next completed frame.
- Boundaries:
  - A new start bit is detected the cycle after return to IDLE. No dead time.
  - A break (rx held low) completes the frame with dout=0 and frame_err=1, then re-enters START.
  - Reset mid-frame aborts at once. No done tick. The external counter is not touched by this block's reset.
  - Compares are exact equality. The counter never needs to wrap because LOAD occurs at the terminal value.

Optional Feature:
- UART_PARITY_EN defined:
  - PARITY state is inserted between DATA and STOP.
  - On s_tick with cnt_q==15: LOAD, sample rx_s as the parity bit, go STOP.
  - parity_err = (^shift ^ rx_s) for even, or its inverse when PAR_ODD=1. It updates with dout at the done tick.
- Undefined: no PARITY state; parity_err tied 0.

Decomposition:
- Shared header uart_defs.vh (the package equivalent) holds:
  - state encodings IDLE/START/DATA/PARITY/STOP as 3-bit localparams;
  - counter mode encodings HOLD/LOAD/INC;
  - START_MID=7, BIT_LAST=15.
- One sub-module: rx_sync (2-FF synchronizer, async active-low reset to 1).

Test Plan:
- Nominal frame 0x55, 8N1, s_tick every 4 clk -> one rx_done_tick, dout=0x55, frame_err=0. Done tick falls 16*(1/2+8+1)=152 ticks after the start edge, ±1 tick.
- Back-to-back frames 0xA3 then 0x0F, no idle gap -> two done ticks, dout 0xA3 then 0x0F, both with frame_err=0.
- Glitch: rx low for 3 ticks, then high -> return to IDLE, no done tick, dout unchanged.
- Stop bit forced low, data 0xFF -> dout=0xFF, frame_err=1. A following good frame 0x12 clears it to 0.
- Reset pulse at data bit 4 of 0x3C -> outputs return to reset values at once, no done tick. The next frame 0x81 is received correctly.
- With UART_PARITY_EN and PAR_ODD=0: frame 0x07 with parity 1 -> parity_err=0. Same frame with parity 0 -> parity_err=1.
